// File: rtl/preload_ctrl_pkg.sv
// rtl/preload_ctrl_pkg.sv - shared width constant and sequencer state encoding
package preload_ctrl_pkg;

  localparam int PL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2
  } pl_state_t;

endpackage

// File: rtl/preload_fifo.sv
// rtl/preload_fifo.sv - synchronous request FIFO, DEPTH x WIDTH, registered occupancy
module preload_fifo
  import preload_ctrl_pkg::*;
#(
  parameter int WIDTH = PL_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push is refused when full even if the same edge pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/preload_ctrl.sv
// rtl/preload_ctrl.sv - queues preload requests, pulses the counter, verifies qout and retries
module preload_ctrl
  import preload_ctrl_pkg::*;
#(
  parameter int WIDTH     = PL_WIDTH,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int GAP       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  output logic                       preload,
  output logic [WIDTH-1:0]           pl_data,
  input  logic [WIDTH-1:0]           qout,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  pl_state_t        state;
  logic [WIDTH-1:0] exp_val;
  logic [RW-1:0]    retry;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             match;
  logic             give_up;
  logic             pop;

  assign match   = (qout == exp_val);
  assign give_up = (retry == RW'(MAX_RETRY));
  // Head leaves the queue only when VERIFY resolves, so retries re-use exp_val.
  assign pop     = (state == ST_VERIFY) && (match || give_up);

  assign req_ready = !full;
  assign busy      = (state != ST_IDLE) || !empty;

  preload_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .pop   (pop),
    .wdata (req_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      exp_val <= '0;
      retry   <= '0;
      gap_cnt <= '0;
      preload <= 1'b0;
      pl_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      preload <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (!empty) begin
            exp_val <= head;
            pl_data <= head;
            retry   <= '0;
            preload <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (match) begin
            done    <= 1'b1;
            gap_cnt <= GW'(GAP);
            state   <= ST_IDLE;
          end else if (!give_up) begin
            retry   <= retry + 1'b1;
            pl_data <= exp_val;
            preload <= 1'b1;
            state   <= ST_LOAD;
          end else begin
            err     <= 1'b1;
            gap_cnt <= GW'(GAP);
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_preload_ctrl.sv
// tb/tb_preload_ctrl.sv - directed bench: preload_ctrl driving a preloadable counter model
module tb_preload_ctrl;
  import preload_ctrl_pkg::*;

  localparam int W  = PL_WIDTH;
  localparam int DP = 4;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_data = '0;
  logic          preload;
  logic [W-1:0]  pl_data;
  logic [W-1:0]  qout;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] level;

  logic [W-1:0]  cnt;
  bit            bad = 1'b0;
  bit            spacing_en = 1'b0;
  logic          prev_pre = 1'b0;
  logic [W-1:0]  last_pl = '0;
  logic [W-1:0]  exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_pre_cyc = -1;
  int            n_pre = 0;
  int            n_done = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  preload_ctrl #(.WIDTH(W), .DEPTH(DP), .MAX_RETRY(2), .GAP(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .preload   (preload),
    .pl_data   (pl_data),
    .qout      (qout),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .level     (level)
  );

  // Preloadable free-running counter the controller drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (preload) cnt <= pl_data;
    else              cnt <= cnt + 1'b1;
  end

  assign qout = bad ? (cnt ^ W'(1)) : cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] head_v;
    if (preload) begin
      check("preload_not_back_to_back", prev_pre, 0);
      check("preload_has_request", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("pl_data_order", pl_data, exp_q[0]);
      if (spacing_en && last_pre_cyc >= 0) check("preload_spacing", cyc - last_pre_cyc, 3);
      last_pre_cyc = cyc;
      last_pl = pl_data;
      n_pre++;
    end
    if (done || err) check("done_err_exclusive", done && err, 0);
    if (done || err) begin
      check("pulse_has_request", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        head_v = exp_q.pop_front();
        check("pulse_value", last_pl, head_v);
      end
    end
    if (done) begin
      check("done_expected", bad, 0);
      n_done++;
    end
    if (err) begin
      check("err_expected", bad, 1);
      n_err++;
    end
    prev_pre = preload;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic send(input logic [W-1:0] v);
    req_valid = 1'b1;
    req_data  = v;
    check("req_ready_on_send", req_ready, 1);
    exp_q.push_back(v);
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < max) begin
      cycle();
      k++;
    end
    check(tag, busy || exp_q.size() != 0, 0);
  endtask

  initial begin
    int d0, e0, p0;

    // 1: reset held 3 cycles
    repeat (3) @(negedge clk);
    check("rst_preload", preload, 0);
    check("rst_pl_data", pl_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_level", level, 0);
    reset = 1'b1;
    cycle();
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_level", level, 0);

    // 2: single request, cycle-exact latency
    d0 = n_done;
    send(8'd50);
    check("t2_no_preload_yet", preload, 0);
    check("t2_level", level, 1);
    check("t2_busy", busy, 1);
    cycle();
    check("t2_preload", preload, 1);
    check("t2_pl_data", pl_data, 50);
    cycle();
    check("t2_qout_loaded", qout, 50);
    check("t2_no_done_yet", done, 0);
    check("t2_verify_no_preload", preload, 0);
    cycle();
    check("t2_done", done, 1);
    check("t2_qout_51", qout, 51);
    cycle();
    check("t2_qout_52", qout, 52);
    check("t2_idle", busy, 0);
    check("t2_done_count", n_done - d0, 1);

    // 3: back-to-back fill until full; pop on the 4th edge keeps one slot free
    d0 = n_done;
    spacing_en = 1'b1;
    last_pre_cyc = -1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data  = W'(10 * (i + 1));
      check("t3_ready_accept", req_ready, 1);
      exp_q.push_back(W'(10 * (i + 1)));
      cycle();
    end
    req_data = 8'd60;
    check("t3_ready_full", req_ready, 0);
    check("t3_level_full", level, 4);
    cycle();
    req_valid = 1'b0;
    wait_idle("t3_drain_timeout", 60);
    spacing_en = 1'b0;
    check("t3_done_count", n_done - d0, 5);
    check("t3_level_empty", level, 0);

    // 4: every verify mismatches -> 1+MAX_RETRY pulses then err
    d0 = n_done; e0 = n_err; p0 = n_pre;
    bad = 1'b1;
    send(8'd77);
    wait_idle("t4_err_timeout", 40);
    check("t4_preload_pulses", n_pre - p0, 3);
    check("t4_err_count", n_err - e0, 1);
    check("t4_no_done", n_done - d0, 0);
    bad = 1'b0;
    send(8'd99);
    wait_idle("t4_recover_timeout", 40);
    check("t4_recover_done", n_done - d0, 1);
    check("t4_no_extra_err", n_err - e0, 1);

    // 5: wrap values
    d0 = n_done; e0 = n_err;
    send(8'hFF);
    wait_idle("t5_ff_timeout", 40);
    send(8'h00);
    wait_idle("t5_00_timeout", 40);
    check("t5_done_count", n_done - d0, 2);
    check("t5_no_err", n_err - e0, 0);

    // 6: reset while in VERIFY
    d0 = n_done; e0 = n_err;
    send(8'd33);
    cycle();
    check("t6_preload_seen", preload, 1);
    cycle();
    reset = 1'b0;
    #1;
    check("t6_rst_preload", preload, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_level", level, 0);
    exp_q.delete();
    prev_pre = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    repeat (6) cycle();
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_err", n_err - e0, 0);
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
